wb_commit_stage: RTL and testbench
==================================

// Module: wb_commit_stage
// PURPOSE
// - Consumer end of the MEM->WB pipeline register: takes latched EX result, raw memory word and 8-bit control.
// - Aligns and extends load data, picks the write-back source, and drives the register-file write port.
// - Keeps a sticky last-write forwarding register and flags misaligned loads.
// - Output registered: one cycle from the MEM->WB register outputs to the register-file write.
// PARAMETERS
// - size      32  datapath width (32 only for load alignment; other values untested)
// - REG_ADDR  5   register-file address width
// PORTS
// - clk               in   1         pipeline clock, rising edge
// - reset             in   1         synchronous, active-low
// - ex_stage_result_i in   size      ALU result; load effective address when mem_to_reg=1
// - mem_stage_result_i in  size      raw aligned 32-bit word from data memory
// - control_signal_i  in   8         [0] reg_write, [1] mem_to_reg, [2] instr_valid, [5:3] load funct3, [7:6] reserved (ignored)
// - rd_addr_i         in   REG_ADDR  destination register
// - flush_i           in   1         kill current input (treat as bubble)
// - rf_we_o           out  1         register-file write enable
// - rf_waddr_o        out  REG_ADDR  register-file write address
// - rf_wdata_o        out  size      register-file write data
// - fwd_valid_o       out  1         forwarding register holds a committed write
// - fwd_addr_o        out  REG_ADDR  address of the last committed write
// - fwd_data_o        out  size      data of the last committed write
// - misalign_o        out  1         one-cycle pulse: misaligned load dropped
// - instret_o         out  64        retired-instruction count (WB_INSTRET_EN only)
// BEHAVIOUR
// - Reset: all outputs 0 on the first clk edge with reset=0. Reset takes priority over flush_i and all inputs.
// - Load extract (addr = ex_stage_result_i[1:0]):
//   - LB/LBU (000/100): byte at addr, sign-/zero-extended.
//   - LH/LHU (001/101): half at addr[1]; misaligned if addr[0]=1.
//   - LW (010): misaligned if addr!=0.
//   - Other funct3 values: result 0; never flagged misaligned.
// - wdata = mem_to_reg ? extracted_load : ex_stage_result_i.
// - mis = mem_to_reg & misaligned & !flush_i.
// - Each edge:
//   - rf_we_o <= reg_write & !flush_i & !mis & (rd_addr_i!=0)
//   - rf_waddr_o <= rd_addr_i; rf_wdata_o <= wdata
//   - misalign_o <= mis
// - x0 is never written, and a write to x0 never updates the forwarding register.
// - Forwarding register: loads the same values as the rf_* outputs whenever the next rf_we_o is 1.
//   - Holds otherwise (sticky across bubbles and flushes); fwd_valid_o is set on the first write.
// - Cleared by reset only.
// - Back-to-back writes to the same rd: the newer write wins, with no gap cycle.
// - Flush together with a misaligned load: flush wins; misalign_o stays 0.
// - No stall input: the stage accepts one input every cycle.
// CONFIGURATION
// - WB_INSTRET_EN defined:
//   - 64-bit counter, +1 on each edge with instr_valid & !flush_i & !mis.
//   - Wraps 2^64-1 -> 0.
//   - Counts retirements with reg_write=0 and rd=x0.
// - WB_INSTRET_EN undefined: no counter flops; instret_o ties to 64'd0.
// STRUCTURE
// - Package wb_pkg:
//   - control bit index localparams (CTL_REG_WRITE=0, CTL_MEM_TO_REG=1, CTL_VALID=2, CTL_F3_LSB=3)
//   - load funct3 enum typedef (LB, LH, LW, LBU, LHU)
// - Sub-module wb_load_align: combinational; inputs word, addr[1:0], funct3; outputs data and misaligned.
// - Top: control decode, output/forwarding flops, optional counter.
// TESTING
// - ALU write-back: ctl=8'b00000101, rd=5, ex=32'hDEAD_BEEF.
//   - Next cycle: rf_we=1, waddr=5, wdata=DEADBEEF; fwd mirrors it.
// - LB sign-extend: mem=32'h80FF_7F01, addr=...3, f3=000, mem_to_reg=1 -> wdata=32'hFFFF_FF80.
//   - Same word with f3=100 (LBU) -> 32'h0000_0080.
// - Misaligned LH: addr=...1, f3=001, reg_write=1.
//   - Result: rf_we=0, misalign_o=1 for exactly one cycle, fwd unchanged.
//   - instret does not increment.
// - x0 and flush:
//   - rd=0 with reg_write=1 -> rf_we=0, fwd unchanged.
//   - flush_i=1 on a valid write -> rf_we=0, no count.
// - Reset mid-stream: after writes, reset=0 for one edge -> all outputs 0 and fwd_valid=0.
// - Counter wrap (WB_INSTRET_EN): force counter to 2^64-1, one valid retire -> instret_o=0.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the write-back commit stage: control-byte bit
// positions and the load funct3 encodings understood by the load aligner.
package wb_pkg;

  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_VALID      = 2;
  localparam int CTL_F3_LSB     = 3;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/wb_commit_stage_if.sv
// MEM->WB boundary bundle: pipeline-register outputs into the commit stage
// and the register-file write / forwarding / status outputs back out.
// master = upstream pipeline + consumers, slave = commit stage.
interface wb_commit_if #(
  parameter int size     = 32,
  parameter int REG_ADDR = 5
);
  logic [size-1:0]     ex_stage_result_i;
  logic [size-1:0]     mem_stage_result_i;
  logic [7:0]          control_signal_i;
  logic [REG_ADDR-1:0] rd_addr_i;
  logic                flush_i;

  logic                rf_we_o;
  logic [REG_ADDR-1:0] rf_waddr_o;
  logic [size-1:0]     rf_wdata_o;
  logic                fwd_valid_o;
  logic [REG_ADDR-1:0] fwd_addr_o;
  logic [size-1:0]     fwd_data_o;
  logic                misalign_o;
  logic [63:0]         instret_o;

  modport master (
    output ex_stage_result_i, mem_stage_result_i, control_signal_i, rd_addr_i, flush_i,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_addr_o, fwd_data_o,
           misalign_o, instret_o
  );

  modport slave (
    input  ex_stage_result_i, mem_stage_result_i, control_signal_i, rd_addr_i, flush_i,
    output rf_we_o, rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_addr_o, fwd_data_o,
           misalign_o, instret_o
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the byte/half addressed by addr_i out of
// the raw memory word, sign- or zero-extends it, and flags misalignment.
// Unknown funct3 values yield 0 and are never reported misaligned.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [size-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [size-1:0] data_o,
  output logic            misaligned_o
);

  function automatic logic [size-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(size-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [size-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{(size-16){sgn & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection by byte address
  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extension and misalignment detection per load type
  always_comb begin
    data_o       = '0;
    misaligned_o = 1'b0;
    case (load_f3_e'(funct3_i))
      LB:  data_o = ext8(byte_sel, 1'b1);
      LBU: data_o = ext8(byte_sel, 1'b0);
      LH: begin
        data_o       = ext16(half_sel, 1'b1);
        misaligned_o = addr_i[0];
      end
      LHU: begin
        data_o       = ext16(half_sel, 1'b0);
        misaligned_o = addr_i[0];
      end
      LW: begin
        data_o       = word_i;
        misaligned_o = (addr_i != 2'd0);
      end
      default: begin
        data_o       = '0;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back commit stage: decodes the MEM->WB control byte, selects the
// write-back value, registers the register-file write port, keeps a sticky
// last-write forwarding register and pulses misalign_o on dropped loads.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN;
// otherwise instret_o is tied to zero and no counter flops exist.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int size     = 32,
  parameter int REG_ADDR = 5
) (
  input  logic       clk,
  input  logic       reset,
  wb_commit_if.slave bus
);

  logic                reg_write;
  logic                mem_to_reg;
  logic                instr_valid;
  logic [2:0]          funct3;
  logic                ctl_unused;
  logic [size-1:0]     load_data;
  logic                load_mis;

  logic                mis_d;
  logic                we_d;
  logic [size-1:0]     wdata_d;
  logic                retire_d;

  logic                rf_we_q;
  logic [REG_ADDR-1:0] rf_waddr_q;
  logic [size-1:0]     rf_wdata_q;
  logic                misalign_q;
  logic                fwd_valid_q;
  logic [REG_ADDR-1:0] fwd_addr_q;
  logic [size-1:0]     fwd_data_q;

  assign reg_write   = bus.control_signal_i[CTL_REG_WRITE];
  assign mem_to_reg  = bus.control_signal_i[CTL_MEM_TO_REG];
  assign instr_valid = bus.control_signal_i[CTL_VALID];
  assign funct3      = bus.control_signal_i[CTL_F3_LSB +: 3];
  assign ctl_unused  = ^bus.control_signal_i[7:6];

  wb_load_align #(.size(size)) u_align (
    .word_i       (bus.mem_stage_result_i),
    .addr_i       (bus.ex_stage_result_i[1:0]),
    .funct3_i     (funct3),
    .data_o       (load_data),
    .misaligned_o (load_mis)
  );

  // Next-state decode: a flush masks both the write and the misalign report
  always_comb begin
    mis_d    = mem_to_reg & load_mis & ~bus.flush_i;
    we_d     = reg_write & ~bus.flush_i & ~mis_d & (bus.rd_addr_i != '0);
    wdata_d  = mem_to_reg ? load_data : bus.ex_stage_result_i;
    retire_d = instr_valid & ~bus.flush_i & ~mis_d;
  end

  // Register-file port and forwarding register; forwarding updates only on
  // real writes so it stays sticky across bubbles, flushes and x0 targets
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      misalign_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      rf_we_q    <= we_d;
      rf_waddr_q <= bus.rd_addr_i;
      rf_wdata_q <= wdata_d;
      misalign_q <= mis_d;
      if (we_d) begin
        fwd_valid_q <= 1'b1;
        fwd_addr_q  <= bus.rd_addr_i;
        fwd_data_q  <= wdata_d;
      end
    end
  end

  assign bus.rf_we_o     = rf_we_q;
  assign bus.rf_waddr_o  = rf_waddr_q;
  assign bus.rf_wdata_o  = rf_wdata_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.fwd_valid_o = fwd_valid_q;
  assign bus.fwd_addr_o  = fwd_addr_q;
  assign bus.fwd_data_o  = fwd_data_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk) begin
    if (!reset) instret_q <= '0;
    else if (retire_d) instret_q <= instret_q + 64'd1;
  end

  assign bus.instret_o = instret_q;
`else
  logic retire_unused;
  assign retire_unused = retire_d;
  assign bus.instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Testbench for wb_commit_stage: directed vector table, hand sequences for
// reset and counter wrap, then randomized traffic against a reference model.
module tb_wb_commit_stage;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wb_commit_if #(.size(32), .REG_ADDR(5)) bus ();

  wb_commit_stage #(.size(32), .REG_ADDR(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mis;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
    logic [63:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] ex;
    logic [31:0] mem;
    logic        fl;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mis;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_fv;
  logic [4:0]  m_fa;
  logic [31:0] m_fd;
  logic [63:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] mem, input int a, input int f3);
    int unsigned b;
    int unsigned h;
    b = (mem >> (8 * a)) & 32'hFF;
    h = (mem >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      2: return mem;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic load_mis(input int a, input int f3);
    return ((f3 == 1 || f3 == 5) && (a % 2 == 1)) || (f3 == 2 && a != 0);
  endfunction

  task automatic model_step(input logic rst_n, input logic [7:0] ctl, input logic [4:0] rd,
                            input logic [31:0] ex, input logic [31:0] mem, input logic fl,
                            output exp_t e);
    int   a;
    int   f3;
    logic mis;
    logic we;
    e = '{default: '0};
    if (!rst_n) begin
      m_fv = 0; m_fa = 0; m_fd = 0; m_cnt = 0;
      return;
    end
    a   = int'(ex[1:0]);
    f3  = int'(ctl[5:3]);
    mis = ctl[1] && load_mis(a, f3) && !fl;
    we  = ctl[0] && !fl && !mis && (rd != 0);
    e.we  = we;
    e.wa  = rd;
    e.wd  = ctl[1] ? load_val(mem, a, f3) : ex;
    e.mis = mis;
    if (we) begin
      m_fv = 1'b1; m_fa = rd; m_fd = e.wd;
    end
    if (ctl[2] && !fl && !mis) m_cnt = m_cnt + 64'd1;
    e.fv = m_fv; e.fa = m_fa; e.fd = m_fd;
`ifdef WB_INSTRET_EN
    e.cnt = m_cnt;
`else
    e.cnt = 64'd0;
`endif
  endtask

  task automatic drive(input logic rst_n, input logic [7:0] ctl, input logic [4:0] rd,
                       input logic [31:0] ex, input logic [31:0] mem, input logic fl);
    reset                  = rst_n;
    bus.control_signal_i   = ctl;
    bus.rd_addr_i          = rd;
    bus.ex_stage_result_i  = ex;
    bus.mem_stage_result_i = mem;
    bus.flush_i            = fl;
  endtask

  task automatic check_exp(input string tag, input exp_t e, input logic skip_wd);
    chk({tag, ".rf_we"}, 64'(bus.rf_we_o), 64'(e.we));
    chk({tag, ".rf_waddr"}, 64'(bus.rf_waddr_o), 64'(e.wa));
    if (!skip_wd) chk({tag, ".rf_wdata"}, 64'(bus.rf_wdata_o), 64'(e.wd));
    chk({tag, ".misalign"}, 64'(bus.misalign_o), 64'(e.mis));
    chk({tag, ".fwd_valid"}, 64'(bus.fwd_valid_o), 64'(e.fv));
    chk({tag, ".fwd_addr"}, 64'(bus.fwd_addr_o), 64'(e.fa));
    chk({tag, ".fwd_data"}, 64'(bus.fwd_data_o), 64'(e.fd));
    chk({tag, ".instret"}, bus.instret_o, e.cnt);
  endtask

  vec_t tbl[13];
  exp_t e;

  initial begin
    tbl[0]  = '{8'b00000101, 5'd5,  32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF};
    tbl[1]  = '{8'b00000111, 5'd6,  32'h0000_1003, 32'h80FF_7F01, 1'b0, 1'b1, 5'd6,  32'hFFFF_FF80, 1'b0, 1'b1, 5'd6,  32'hFFFF_FF80};
    tbl[2]  = '{8'b00100111, 5'd7,  32'h0000_1003, 32'h80FF_7F01, 1'b0, 1'b1, 5'd7,  32'h0000_0080, 1'b0, 1'b1, 5'd7,  32'h0000_0080};
    tbl[3]  = '{8'b00001111, 5'd8,  32'h0000_1001, 32'h80FF_7F01, 1'b0, 1'b0, 5'd8,  32'h0000_7F01, 1'b1, 1'b1, 5'd7,  32'h0000_0080};
    tbl[4]  = '{8'b00000000, 5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd7,  32'h0000_0080};
    tbl[5]  = '{8'b00000101, 5'd0,  32'h1234_5678, 32'h0,         1'b0, 1'b0, 5'd0,  32'h1234_5678, 1'b0, 1'b1, 5'd7,  32'h0000_0080};
    tbl[6]  = '{8'b00000101, 5'd9,  32'h0000_CAFE, 32'h0,         1'b1, 1'b0, 5'd9,  32'h0000_CAFE, 1'b0, 1'b1, 5'd7,  32'h0000_0080};
    tbl[7]  = '{8'b00010111, 5'd10, 32'h0000_0002, 32'hAABB_CCDD, 1'b1, 1'b0, 5'd10, 32'hAABB_CCDD, 1'b0, 1'b1, 5'd7,  32'h0000_0080};
    tbl[8]  = '{8'b00101111, 5'd11, 32'h0000_0002, 32'h80FF_7F01, 1'b0, 1'b1, 5'd11, 32'h0000_80FF, 1'b0, 1'b1, 5'd11, 32'h0000_80FF};
    tbl[9]  = '{8'b00001111, 5'd12, 32'h0000_0002, 32'h80FF_7F01, 1'b0, 1'b1, 5'd12, 32'hFFFF_80FF, 1'b0, 1'b1, 5'd12, 32'hFFFF_80FF};
    tbl[10] = '{8'b00000101, 5'd12, 32'h0000_0001, 32'h0,         1'b0, 1'b1, 5'd12, 32'h0000_0001, 1'b0, 1'b1, 5'd12, 32'h0000_0001};
    tbl[11] = '{8'b00011111, 5'd13, 32'h0000_0003, 32'h80FF_7F01, 1'b0, 1'b1, 5'd13, 32'h0000_0000, 1'b0, 1'b1, 5'd13, 32'h0000_0000};
    tbl[12] = '{8'b11000101, 5'd14, 32'h0000_0055, 32'h0,         1'b0, 1'b1, 5'd14, 32'h0000_0055, 1'b0, 1'b1, 5'd14, 32'h0000_0055};

    // Reset state
    drive(1'b0, 8'h05, 5'd3, 32'h1111_1111, 32'h0, 1'b0);
    model_step(1'b0, 8'h05, 5'd3, 32'h1111_1111, 32'h0, 1'b0, e);
    repeat (2) @(posedge clk);
    #1;
    check_exp("reset", e, 1'b0);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].ctl, tbl[i].rd, tbl[i].ex, tbl[i].mem, tbl[i].fl);
      model_step(1'b1, tbl[i].ctl, tbl[i].rd, tbl[i].ex, tbl[i].mem, tbl[i].fl, e);
      @(posedge clk);
      #1;
      e.we = tbl[i].we; e.wa = tbl[i].wa; e.wd = tbl[i].wd; e.mis = tbl[i].mis;
      e.fv = tbl[i].fv; e.fa = tbl[i].fa; e.fd = tbl[i].fd;
      check_exp($sformatf("vec%0d", i), e, 1'b0);
    end

    // Reset mid-stream, with a valid write presented during the reset edge
    drive(1'b0, 8'h05, 5'd3, 32'h7777_7777, 32'h0, 1'b0);
    model_step(1'b0, 8'h05, 5'd3, 32'h7777_7777, 32'h0, 1'b0, e);
    @(posedge clk);
    #1;
    check_exp("midreset", e, 1'b0);
    drive(1'b1, 8'h00, 5'd0, 32'h0, 32'h0, 1'b0);
    model_step(1'b1, 8'h00, 5'd0, 32'h0, 32'h0, 1'b0, e);
    @(posedge clk);
    #1;
    check_exp("postreset_bubble", e, 1'b0);

`ifdef WB_INSTRET_EN
    // Counter wrap from all-ones
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 8'h04, 5'd0, 32'h0, 32'h0, 1'b0);
    model_step(1'b1, 8'h04, 5'd0, 32'h0, 32'h0, 1'b0, e);
    @(posedge clk);
    #1;
    chk("instret_wrap", bus.instret_o, 64'd0);
    check_exp("wrap", e, 1'b0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic        r_n;
      logic [7:0]  ctl;
      logic [4:0]  rd;
      logic [31:0] ex;
      logic [31:0] mem;
      logic        fl;
      logic        skip;
      r_n = ($urandom_range(0, 63) != 0);
      ctl = 8'($urandom);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ex  = $urandom;
      mem = $urandom;
      fl  = ($urandom_range(0, 7) == 0);
      drive(r_n, ctl, rd, ex, mem, fl);
      model_step(r_n, ctl, rd, ex, mem, fl, e);
      skip = r_n && ctl[1] && load_mis(int'(ex[1:0]), int'(ctl[5:3]));
      @(posedge clk);
      #1;
      check_exp($sformatf("rand%0d", i), e, skip);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
